// File: rtl/wb_pantalla_pkg.sv
// Shared register map, bit positions, default video timing and bus FSM states.
// Pure declarations: no latency, no flow control.
package wb_pantalla_pkg;

    // Word offsets decoded from wb_adr_i[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_ADDR   = 3'd1;
    localparam logic [2:0] REG_PIXEL  = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AI_BIT     = 1;
    localparam int CTRL_TP_BIT     = 2;
    localparam int STAT_VBLANK_BIT = 0;
    localparam int STAT_DONE_BIT   = 1;
    localparam int STAT_CNT_LSB    = 16;

    localparam int DEF_COLOR_W     = 4;
    localparam int DEF_H_ACT       = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACT       = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SCALE_SHIFT = 3;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_RD_WAIT,
        BUS_ACK
    } bus_state_t;

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters with raw (undelayed) active-low syncs, active/vblank flags and frame tick.
// Latency: flags are combinational from the counters; free-running, no backpressure.
module vga_timing
    import wb_pantalla_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
)(
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             vblank,
    output logic             frame_tick
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACT + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] H_SS = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] H_SE = CNT_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] V_SE = CNT_W'(V_ACT + V_FP + V_SYNC);

    logic h_last, v_last;
    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign hsync      = ~((hcnt >= H_SS) && (hcnt < H_SE));
    assign vsync      = ~((vcnt >= V_SS) && (vcnt < V_SE));
    assign active     = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    assign vblank     = (vcnt >= V_ACT_C);
    assign frame_tick = h_last & v_last;

endmodule

// File: rtl/wb_pantalla_fb.sv
// Wishbone-mapped downscaled framebuffer driving VGA; WB_PANTALLA_FB_TESTPAT_EN adds colour bars.
// Latency: ack 1 clk (PIXEL read 2 clk), video 2 clk; no backpressure, one bus access in flight.
module wb_pantalla_fb
    import wb_pantalla_pkg::*;
#(
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int H_ACT       = DEF_H_ACT,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACT       = DEF_V_ACT,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    input  logic               wb_we_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               P_Hsync,
    output logic               P_Vsync,
    output logic [COLOR_W-1:0] P_red,
    output logic [COLOR_W-1:0] P_green,
    output logic [COLOR_W-1:0] P_blue
);
    localparam int FB_W     = H_ACT >> SCALE_SHIFT;
    localparam int FB_H     = V_ACT >> SCALE_SHIFT;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int AW       = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int PIX_W    = 3 * COLOR_W;
    localparam logic [AW-1:0] ADDR_LAST = AW'(FB_DEPTH - 1);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             hsync, vsync, vid_active, vblank, frame_tick;

    vga_timing #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
        .hsync(hsync), .vsync(vsync), .active(vid_active),
        .vblank(vblank), .frame_tick(frame_tick)
    );

    bus_state_t        bus_state, bus_next;
    logic              req, pix_rd, fb_we;
    logic [2:0]        reg_sel;
    logic              ctrl_en, ctrl_ai, ctrl_tp;
    logic [AW-1:0]     addr, addr_inc;
    logic [31:0]       addr_mod, rd_word;
    logic              frame_done;
    logic [15:0]       frame_cnt;
    logic [PIX_W-1:0]  fb [FB_DEPTH];
    logic [PIX_W-1:0]  bus_rd_q, vid_pix_q, pix_next;
    logic [31:0]       vid_idx;
    logic [AW-1:0]     vid_addr;
    logic              hs_d1, vs_d1, en_d1;

    assign reg_sel  = wb_adr_i[4:2];
    assign req      = wb_stb_i & wb_cyc_i & (bus_state == BUS_IDLE);
    assign pix_rd   = req & ~wb_we_i & (reg_sel == REG_PIXEL);
    assign fb_we    = req & wb_we_i & (reg_sel == REG_PIXEL);
    assign addr_mod = wb_dat_i % 32'(FB_DEPTH);
    assign addr_inc = (addr == ADDR_LAST) ? '0 : addr + 1'b1;
    assign wb_ack_o = (bus_state == BUS_ACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus_state <= BUS_IDLE;
        else        bus_state <= bus_next;
    end

    always_comb begin
        bus_next = bus_state;
        case (bus_state)
            BUS_IDLE:    if (req) bus_next = pix_rd ? BUS_RD_WAIT : BUS_ACK;
            BUS_RD_WAIT: bus_next = BUS_ACK;
            default:     bus_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_word[CTRL_EN_BIT] = ctrl_en;
                rd_word[CTRL_AI_BIT] = ctrl_ai;
                rd_word[CTRL_TP_BIT] = ctrl_tp;
            end
            REG_ADDR: rd_word = 32'(addr);
            REG_STATUS: begin
                rd_word[STAT_VBLANK_BIT]      = vblank;
                rd_word[STAT_DONE_BIT]        = frame_done;
                rd_word[STAT_CNT_LSB +: 16]   = frame_cnt;
            end
            default: rd_word = '0;
        endcase
    end

`ifdef WB_PANTALLA_FB_TESTPAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ctrl_tp <= 1'b0;
        else if (req && wb_we_i && reg_sel == REG_CTRL)
            ctrl_tp <= wb_dat_i[CTRL_TP_BIT];
    end
`else
    assign ctrl_tp = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en    <= 1'b0;
            ctrl_ai    <= 1'b0;
            addr       <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            wb_dat_o   <= '0;
        end else begin
            if (frame_tick)
                frame_cnt <= frame_cnt + 16'd1;
            // A frame tick wins over a same-cycle clear so no frame end is lost
            if (frame_tick)
                frame_done <= 1'b1;
            else if (req && wb_we_i && reg_sel == REG_STATUS && wb_dat_i[STAT_DONE_BIT])
                frame_done <= 1'b0;
            if (req) begin
                if (wb_we_i) begin
                    case (reg_sel)
                        REG_CTRL: begin
                            ctrl_en <= wb_dat_i[CTRL_EN_BIT];
                            ctrl_ai <= wb_dat_i[CTRL_AI_BIT];
                        end
                        REG_ADDR:  addr <= addr_mod[AW-1:0];
                        REG_PIXEL: if (ctrl_ai) addr <= addr_inc;
                        default: ;
                    endcase
                end else begin
                    wb_dat_o <= rd_word;
                    if (reg_sel == REG_PIXEL && ctrl_ai)
                        addr <= addr_inc;
                end
            end
            if (bus_state == BUS_RD_WAIT)
                wb_dat_o <= 32'(bus_rd_q);
        end
    end

    // Both reads sample before the write lands, so a colliding video read sees old data
    always_ff @(posedge clk) begin
        if (fb_we)
            fb[addr] <= wb_dat_i[PIX_W-1:0];
        bus_rd_q  <= fb[addr];
        vid_pix_q <= fb[vid_addr];
    end

    assign vid_idx  = 32'(vcnt >> SCALE_SHIFT) * 32'(FB_W) + 32'(hcnt >> SCALE_SHIFT);
    assign vid_addr = vid_active ? vid_idx[AW-1:0] : '0;

`ifdef WB_PANTALLA_FB_TESTPAT_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACT / 8);
    logic [CNT_W-1:0] bar_idx;
    logic [2:0]       bar_d1;
    logic             tp_d1;
    logic             unused_bar;
    assign bar_idx    = hcnt / BAR_W;
    assign unused_bar = ^bar_idx[CNT_W-1:3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bar_d1 <= '0;
            tp_d1  <= 1'b0;
        end else begin
            bar_d1 <= bar_idx[2:0];
            tp_d1  <= ctrl_tp;
        end
    end
`endif

    always_comb begin
        pix_next = vid_pix_q;
`ifdef WB_PANTALLA_FB_TESTPAT_EN
        if (tp_d1)
            pix_next = {{COLOR_W{bar_d1[2]}}, {COLOR_W{bar_d1[1]}}, {COLOR_W{bar_d1[0]}}};
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_d1   <= 1'b1;
            vs_d1   <= 1'b1;
            en_d1   <= 1'b0;
            P_Hsync <= 1'b1;
            P_Vsync <= 1'b1;
            P_red   <= '0;
            P_green <= '0;
            P_blue  <= '0;
        end else begin
            hs_d1   <= hsync;
            vs_d1   <= vsync;
            en_d1   <= vid_active & ctrl_en;
            P_Hsync <= hs_d1;
            P_Vsync <= vs_d1;
            {P_red, P_green, P_blue} <= en_d1 ? pix_next : '0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:PIX_W],
                           addr_mod[31:AW], vid_idx[31:AW]};

endmodule
